psum_requant_act: RTL and testbench
===================================

PSUM_REQUANT_ACT -- requirements
Module: psum_requant_act

Interface
REQ-001 The block SHALL have parameter IN_DW, default 32, meaning the width of the signed partial sum from the PE column.
REQ-002 The block SHALL have parameter OUT_DW, default 8, meaning the width of the signed quantised activation output.
REQ-003 The block SHALL have parameter MULT_DW, default 16, meaning the width of the unsigned requantisation multiplier.
REQ-004 The block SHALL have port wclk, input, 1, the clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-006 The block SHALL have port in_valid, input, 1, meaning psum_32b and its sideband fields are valid.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the block accepts an input this cycle.
REQ-008 The block SHALL have port psum_32b, input, IN_DW signed, the accumulated PE result.
REQ-009 The block SHALL have port bias, input, IN_DW signed, the per-channel bias.
REQ-010 The block SHALL have port scale_mult, input, MULT_DW unsigned, the requantisation multiplier.
REQ-011 The block SHALL have port shift, input, 5, the right-shift amount (0..31).
REQ-012 The block SHALL have port act_sel, input, 2: 00 none, 01 ReLU, 10 hard sigmoid, 11 hard tanh.
REQ-013 The block SHALL have port clr_cnt, input, 1, a synchronous clear of sat_count.
REQ-014 The block SHALL have port out_valid, output, 1, meaning out_8b is valid.
REQ-015 The block SHALL have port out_ready, input, 1, meaning downstream accepts out_8b.
REQ-016 The block SHALL have port out_8b, output, OUT_DW signed, the activated int8 result.
REQ-017 The block SHALL have port sat_flag, output, 1, meaning the current output saturated in some stage.
REQ-018 The block SHALL have port sat_count, output, 16, the saturating count of delivered saturated outputs.

Function
REQ-019 The block SHALL form a 3-stage pipeline: S1 bias add, S2 multiply, S3 round/shift/saturate/activate; latency is 3 cycles from acceptance to out_valid when unstalled.
REQ-020 The pipeline SHALL advance only when en = !out_valid || out_ready, and in_ready SHALL equal en.
REQ-021 An input SHALL be accepted when in_valid && in_ready; bias, scale_mult, shift and act_sel SHALL be captured with psum_32b and carried down the pipe alongside it.
REQ-022 Each stage SHALL have a valid bit, and bubbles SHALL propagate as invalid stages.
REQ-023 When stalled, all stage registers and outputs SHALL hold unchanged, with no loss and no duplication.
REQ-024 S1 SHALL compute sum = psum_32b + bias at 33 bits, saturate it to the IN_DW signed range, and set a stage saturation bit on clamp.
REQ-025 S2 SHALL compute prod = sum * {0, scale_mult} as a signed IN_DW+MULT_DW+1-bit product.
REQ-026 S3 SHALL compute r = (prod + (1 << (shift-1))) >>> shift when shift > 0, and r = prod when shift = 0.
REQ-027 S3 SHALL clamp r to [-128, 127] and OR the clamp indication into the saturation bit.
REQ-028 S3 SHALL apply act_sel to the clamped value q:
- none: q
- ReLU: max(q, 0)
- hard sigmoid: clamp((q >>> 1) + 64, 0, 127)
- hard tanh: clamp(2q, -127, 127)
REQ-029 The activation clamps SHALL NOT set sat_flag.
REQ-030 sat_flag SHALL be registered alongside out_8b and be valid only while out_valid is 1.
REQ-031 sat_count SHALL increment by 1 on each out_valid && out_ready && sat_flag, and saturate at 16'hFFFF.
REQ-032 clr_cnt SHALL zero sat_count and take priority over a simultaneous increment.
REQ-033 Back-to-back inputs SHALL sustain a throughput of 1 result per cycle while out_ready = 1.

Reset
REQ-034 While rst_n = 0, all stage valid bits, out_valid, out_8b, sat_flag and sat_count SHALL be 0, and in_ready SHALL be 1.
REQ-035 Assertion of rst_n mid-operation SHALL discard all in-flight data immediately, with no output produced after release for inputs accepted before reset.

Verification
REQ-036 Basic path: psum=100, bias=-4, scale=128, shift=8, act=00 -> out_8b=48 three cycles later, sat_flag=0; same with act=10 -> 88.
REQ-037 Rounding: scale=1, shift=1, bias=0; psum=3 -> 2; psum=-3 -> -1; psum=1, shift=0 -> 1.
REQ-038 Saturation: psum=0x7FFFFFFF, bias=1, scale=1, shift=0 -> out_8b=127, sat_flag=1, sat_count=1 after handshake; psum=-1000, act=01 -> out_8b=0 with sat_flag=1.
REQ-039 Backpressure: out_ready=0 for 6 cycles with 5 consecutive inputs offered -> exactly 3 held in the pipe, in_ready=0 while the pipe is full, then all 5 delivered in order once out_ready=1.
REQ-040 Counter: 70000 saturated handshakes -> sat_count=0xFFFF; clr_cnt asserted together with a saturated handshake -> sat_count=0.
REQ-041 Reset mid-stream: rst_n pulsed low with 2 items in flight -> out_valid stays 0 after release until a new input has been accepted and 3 cycles have passed.

Source files
------------

// File: rtl/psum_requant_act.sv
// rtl/psum_requant_act.sv - partial-sum requantiser: bias add, scale multiply, round/shift/saturate, activation
module psum_requant_act #(
    parameter int IN_DW   = 32,
    parameter int OUT_DW  = 8,
    parameter int MULT_DW = 16
) (
    input  logic                      wclk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [IN_DW-1:0]   psum_32b,
    input  logic signed [IN_DW-1:0]   bias,
    input  logic [MULT_DW-1:0]        scale_mult,
    input  logic [4:0]                shift,
    input  logic [1:0]                act_sel,
    input  logic                      clr_cnt,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [OUT_DW-1:0]  out_8b,
    output logic                      sat_flag,
    output logic [15:0]               sat_count
);

    localparam int SW = IN_DW + 1;
    localparam int PW = IN_DW + MULT_DW + 1;
    localparam int RW = PW + 1;
    localparam int AW = OUT_DW + 2;

    localparam logic signed [RW-1:0] Q_MAX = RW'((1 << (OUT_DW - 1)) - 1);
    localparam logic signed [RW-1:0] Q_MIN = ~Q_MAX;
    localparam logic signed [AW-1:0] A_MAX = AW'((1 << (OUT_DW - 1)) - 1);
    localparam logic signed [AW-1:0] A_MIN = -A_MAX;
    localparam logic signed [AW-1:0] H_OFF = AW'(1 << (OUT_DW - 2));

    logic en;
    logic accept;

    // One global enable: the whole pipe freezes while the output register is blocked.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;

    // S1: bias add with saturation to the input range
    logic signed [SW-1:0]    sum_full;
    logic signed [IN_DW-1:0] sum_sat;
    logic                    sum_clamp;

    always_comb begin
        sum_full  = {psum_32b[IN_DW-1], psum_32b} + {bias[IN_DW-1], bias};
        sum_clamp = sum_full[SW-1] != sum_full[SW-2];
        sum_sat   = sum_full[IN_DW-1:0];
        if (sum_clamp)
            sum_sat = sum_full[SW-1] ? {1'b1, {(IN_DW-1){1'b0}}} : {1'b0, {(IN_DW-1){1'b1}}};
    end

    logic                    s1_valid;
    logic signed [IN_DW-1:0] s1_sum;
    logic [MULT_DW-1:0]      s1_mult;
    logic [4:0]              s1_shift;
    logic [1:0]              s1_act;
    logic                    s1_sat;

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_mult  <= '0;
            s1_shift <= '0;
            s1_act   <= '0;
            s1_sat   <= 1'b0;
        end else if (en) begin
            s1_valid <= accept;
            s1_sum   <= sum_sat;
            s1_mult  <= scale_mult;
            s1_shift <= shift;
            s1_act   <= act_sel;
            s1_sat   <= sum_clamp;
        end
    end

    // S2: signed product against the zero-extended unsigned multiplier
    logic signed [PW-1:0] prod_a;
    logic signed [PW-1:0] prod_b;
    logic signed [PW-1:0] prod;

    always_comb begin
        prod_a = PW'(s1_sum);
        prod_b = PW'($signed({1'b0, s1_mult}));
        prod   = prod_a * prod_b;
    end

    logic                 s2_valid;
    logic signed [PW-1:0] s2_prod;
    logic [4:0]           s2_shift;
    logic [1:0]           s2_act;
    logic                 s2_sat;

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_prod  <= '0;
            s2_shift <= '0;
            s2_act   <= '0;
            s2_sat   <= 1'b0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_prod  <= prod;
            s2_shift <= s1_shift;
            s2_act   <= s1_act;
            s2_sat   <= s1_sat;
        end
    end

    // S3: round-half-up shift, clamp to the output range, then activation
    logic signed [RW-1:0]     rnd_add;
    logic signed [RW-1:0]     r_sum;
    logic signed [RW-1:0]     r_shr;
    logic signed [OUT_DW-1:0] q;
    logic                     q_clamp;
    logic signed [AW-1:0]     q_ext;
    logic signed [AW-1:0]     act_ext;

    always_comb begin
        rnd_add = '0;
        if (s2_shift != 5'd0)
            rnd_add = RW'(1) <<< (s2_shift - 5'd1);
        r_sum   = RW'(s2_prod) + rnd_add;
        r_shr   = r_sum >>> s2_shift;
        q_clamp = 1'b0;
        q       = r_shr[OUT_DW-1:0];
        if (r_shr > Q_MAX) begin
            q       = Q_MAX[OUT_DW-1:0];
            q_clamp = 1'b1;
        end else if (r_shr < Q_MIN) begin
            q       = Q_MIN[OUT_DW-1:0];
            q_clamp = 1'b1;
        end
        q_ext   = AW'(q);
        act_ext = q_ext;
        case (s2_act)
            2'b01: begin
                if (q_ext[AW-1])
                    act_ext = '0;
            end
            2'b10: begin
                act_ext = (q_ext >>> 1) + H_OFF;
                if (act_ext[AW-1])
                    act_ext = '0;
                else if (act_ext > A_MAX)
                    act_ext = A_MAX;
            end
            2'b11: begin
                act_ext = q_ext <<< 1;
                if (act_ext > A_MAX)
                    act_ext = A_MAX;
                else if (act_ext < A_MIN)
                    act_ext = A_MIN;
            end
            default: act_ext = q_ext;
        endcase
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_8b    <= '0;
            sat_flag  <= 1'b0;
        end else if (en) begin
            out_valid <= s2_valid;
            out_8b    <= act_ext[OUT_DW-1:0];
            sat_flag  <= s2_valid && (s2_sat || q_clamp);
        end
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n)
            sat_count <= '0;
        else if (clr_cnt)
            sat_count <= '0;
        else if (out_valid && out_ready && sat_flag && (sat_count != 16'hFFFF))
            sat_count <= sat_count + 16'd1;
    end

endmodule

// File: tb/tb_psum_requant_act.sv
// tb/tb_psum_requant_act.sv - scoreboard bench for psum_requant_act
module tb_psum_requant_act;

    logic               wclk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] psum_32b;
    logic signed [31:0] bias;
    logic [15:0]        scale_mult;
    logic [4:0]         shift;
    logic [1:0]         act_sel;
    logic               clr_cnt;
    logic               out_valid;
    logic               out_ready;
    logic signed [7:0]  out_8b;
    logic               sat_flag;
    logic [15:0]        sat_count;

    psum_requant_act dut (
        .wclk(wclk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .psum_32b(psum_32b), .bias(bias), .scale_mult(scale_mult),
        .shift(shift), .act_sel(act_sel), .clr_cnt(clr_cnt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_8b(out_8b), .sat_flag(sat_flag), .sat_count(sat_count)
    );

    always #5 wclk = ~wclk;

    int  n_vec = 0;
    int  n_err = 0;
    int  n_pop = 0;
    int  cnt_model = 0;
    int  exp_out_q[$];
    bit  exp_sat_q[$];

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic void ref_model(input longint p, input longint b, input longint m,
                                      input int sh, input int act, output int res, output bit sat);
        longint s, pr, r;
        int     qv, t;
        sat = 0;
        s = p + b;
        if (s > 64'sd2147483647)       begin s = 64'sd2147483647;  sat = 1; end
        else if (s < -64'sd2147483648) begin s = -64'sd2147483648; sat = 1; end
        pr = s * m;
        if (sh == 0) r = pr;
        else         r = (pr + (longint'(1) << (sh - 1))) >>> sh;
        if (r > 127)       begin qv = 127;  sat = 1; end
        else if (r < -128) begin qv = -128; sat = 1; end
        else               qv = int'(r);
        case (act)
            1: res = (qv < 0) ? 0 : qv;
            2: begin t = (qv >>> 1) + 64; res = (t < 0) ? 0 : (t > 127) ? 127 : t; end
            3: begin t = 2 * qv; res = (t < -127) ? -127 : (t > 127) ? 127 : t; end
            default: res = qv;
        endcase
    endfunction

    // Sampled on the falling edge: handshakes seen here commit on the next rising edge.
    task automatic monitor();
        int eo;
        bit es;
        check("sat_count", sat_count, cnt_model);
        if (in_valid && in_ready) begin
            ref_model(psum_32b, bias, scale_mult, shift, act_sel, eo, es);
            exp_out_q.push_back(eo);
            exp_sat_q.push_back(es);
        end
        if (out_valid && out_ready) begin
            if (exp_out_q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                eo = exp_out_q.pop_front();
                es = exp_sat_q.pop_front();
                n_pop++;
                check("out_8b", out_8b, eo);
                check("sat_flag", sat_flag, es);
                if (es && cnt_model < 65535) cnt_model++;
            end
        end
        if (clr_cnt) cnt_model = 0;
    endtask

    task automatic tick();
        @(negedge wclk);
        monitor();
        @(posedge wclk);
        #1;
    endtask

    task automatic drive(input longint p, input longint b, input int sc, input int sh, input int ac);
        psum_32b   = 32'(p);
        bias       = 32'(b);
        scale_mult = 16'(sc);
        shift      = 5'(sh);
        act_sel    = 2'(ac);
    endtask

    task automatic send_one(input string tag, input longint p, input longint b, input int sc,
                            input int sh, input int ac, input int ex, input bit es);
        drive(p, b, sc, sh, ac);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check({tag, "_early"}, out_valid, 0);
        tick();
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_out"}, out_8b, ex);
        check({tag, "_sat"}, sat_flag, es);
        tick();
    endtask

    task automatic rand_drive();
        case ($urandom % 3)
            0: drive($signed($urandom), $signed($urandom), $urandom % 65536, $urandom % 32, $urandom % 4);
            1: drive(longint'($urandom_range(4000)) - 2000, longint'($urandom_range(400)) - 200,
                     $urandom_range(300), $urandom_range(12), $urandom % 4);
            default: drive(longint'($urandom_range(200000)) - 100000, longint'($urandom_range(2000)) - 1000,
                           $urandom % 65536, $urandom_range(31, 14), $urandom % 4);
        endcase
    endtask

    initial begin
        int idx;
        int pops0;

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
        drive(0, 0, 0, 0, 0);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_8b", out_8b, 0);
        check("rst_sat_flag", sat_flag, 0);
        check("rst_sat_count", sat_count, 0);
        repeat (2) @(posedge wclk);
        #1 rst_n = 1'b1;

        send_one("basic", 100, -4, 128, 8, 0, 48, 0);
        send_one("basic_sig", 100, -4, 128, 8, 2, 88, 0);
        send_one("rnd_pos", 3, 0, 1, 1, 0, 2, 0);
        send_one("rnd_neg", -3, 0, 1, 1, 0, -1, 0);
        send_one("rnd_sh0", 1, 0, 1, 0, 0, 1, 0);
        send_one("sat_hi", 64'h7FFFFFFF, 1, 1, 0, 0, 127, 1);
        check("sat_cnt_1", sat_count, 1);
        send_one("sat_relu", -1000, 0, 1, 0, 1, 0, 1);
        send_one("tanh", 50, 0, 1, 0, 3, 100, 0);
        send_one("tanh_neg", -100, 0, 1, 0, 3, -127, 0);

        // Backpressure: five items offered against a blocked output
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = (idx < 5);
            drive(idx * 7 - 9, 3, 5, 1, idx % 4);
            if (in_valid && in_ready) idx++;
            tick();
        end
        check("bp_held", idx, 3);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        pops0 = n_pop;
        out_ready = 1'b1;
        for (int c = 0; c < 30 && (n_pop - pops0) < 5; c++) begin
            in_valid = (idx < 5);
            drive(idx * 7 - 9, 3, 5, 1, idx % 4);
            if (in_valid && in_ready) idx++;
            tick();
        end
        in_valid = 1'b0;
        check("bp_delivered", n_pop - pops0, 5);

        // Randomised traffic with random backpressure and occasional counter clears
        for (int c = 0; c < 2000; c++) begin
            in_valid  = ($urandom % 10) < 7;
            out_ready = ($urandom % 10) < 7;
            clr_cnt   = ($urandom % 50) == 0;
            rand_drive();
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
        repeat (5) tick();
        check("drain_empty", exp_out_q.size(), 0);

        // Counter saturation
        drive(64'h7FFFFFFF, 1, 1, 0, 0);
        in_valid = 1'b1;
        repeat (70000) tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check("cnt_sat", sat_count, 16'hFFFF);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("clr_out_valid", out_valid, 1);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("cnt_clr", sat_count, 0);

        // Reset with two items in flight
        rand_drive();
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_sat_count", sat_count, 0);
        exp_out_q.delete();
        exp_sat_q.delete();
        cnt_model = 0;
        @(posedge wclk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("post_rst_quiet", out_valid, 0);
        end
        send_one("post_rst", 100, -4, 128, 8, 1, 48, 0);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
